// File: rtl/aes_pkg.sv
// -----------------------------------------------------------------------------
// aes_pkg
// Shared definitions for the AES round sequencer and its flag decoder:
//   - key_mode encodings (KM_128 / KM_192 / KM_256; 2'b11 is reserved)
//   - default round counts for each key size
//   - sequencer state encoding (2 bits)
// No ports; imported with "import aes_pkg::*;".
// -----------------------------------------------------------------------------
package aes_pkg;

   // key_mode encodings
   localparam logic [1:0] KM_128 = 2'b00;
   localparam logic [1:0] KM_192 = 2'b01;
   localparam logic [1:0] KM_256 = 2'b10;

   // Default number of rounds per key size
   localparam int AES_NR_128 = 10;
   localparam int AES_NR_192 = 12;
   localparam int AES_NR_256 = 14;

   // Sequencer states
   typedef enum logic [1:0] {
      ST_IDLE = 2'd0,
      ST_RUN  = 2'd1,
      ST_DONE = 2'd2
   } state_t;

endpackage : aes_pkg

// File: rtl/aes_round_flags.sv
// -----------------------------------------------------------------------------
// aes_round_flags
// Purely combinational decoder of the per-round datapath control flags from the
// sequencer registers. Shared with the key expansion controller.
// Ports:
//   state     in   sequencer state (flags only asserted in ST_RUN)
//   round     in   current round index, 0..nr
//   nr        in   round count of the operation
//   first_rnd out  round 0 (initial AddRoundKey)
//   mix_en    out  rounds 1..nr-1 (MixColumns active)
//   pre_last  out  round nr-1 (key unit prefetches final round key)
//   last_rnd  out  round nr (final round, no MixColumns)
// -----------------------------------------------------------------------------
module aes_round_flags
   import aes_pkg::*;
#(
   parameter int CNT_W = 4
) (
   input  state_t           state,
   input  logic [CNT_W-1:0] round,
   input  logic [CNT_W-1:0] nr,
   output logic             first_rnd,
   output logic             mix_en,
   output logic             pre_last,
   output logic             last_rnd
);

   logic             run;
   logic [CNT_W-1:0] nr_m1;

   assign run   = (state == ST_RUN);
   assign nr_m1 = nr - {{(CNT_W-1){1'b0}}, 1'b1};

   always_comb begin
      first_rnd = run && (round == '0);
      // round never exceeds nr in RUN, so first/mix/last are mutually exclusive
      mix_en    = run && (round != '0) && (round < nr);
      pre_last  = run && (round == nr_m1);
      last_rnd  = run && (round == nr);
   end

endmodule : aes_round_flags

// File: rtl/aes_round_sequencer.sv
// -----------------------------------------------------------------------------
// aes_round_sequencer
// Start/busy/done round controller for the AES encryption datapath supporting
// AES-128/192/256 (NR_128/NR_192/NR_256 rounds), with stall, abort and
// back-to-back start.
// Ports:
//   clk       in   system clock, rising edge
//   clr       in   synchronous active-high reset (highest priority)
//   start     in   begin an operation (honoured in IDLE and DONE only)
//   key_mode  in   00=128, 01=192, 10=256, 11=reserved (runs as 128)
//   cnt_en    in   advance the round; low stalls the sequencer
//   abort     in   cancel the operation in progress (no done pulse)
//   busy      out  high in RUN
//   round     out  current round index 0..nr
//   nr        out  round count latched at start
//   first_rnd/mix_en/pre_last/last_rnd  out  per-round datapath flags
//   done      out  single-cycle completion pulse
// All outputs are decoded from registered state only.
// -----------------------------------------------------------------------------
module aes_round_sequencer
   import aes_pkg::*;
#(
   parameter int CNT_W  = 4,
   parameter int NR_128 = AES_NR_128,
   parameter int NR_192 = AES_NR_192,
   parameter int NR_256 = AES_NR_256
) (
   input  logic             clk,
   input  logic             clr,
   input  logic             start,
   input  logic [1:0]       key_mode,
   input  logic             cnt_en,
   input  logic             abort,
   output logic             busy,
   output logic [CNT_W-1:0] round,
   output logic [CNT_W-1:0] nr,
   output logic             first_rnd,
   output logic             mix_en,
   output logic             pre_last,
   output logic             last_rnd,
   output logic             done
);

   state_t           state_q, state_d;
   logic [CNT_W-1:0] round_q, round_d;
   logic [CNT_W-1:0] nr_q,    nr_d;
   logic [CNT_W-1:0] nr_sel;

   // Round count selected by key_mode; the reserved code falls back to 128
   always_comb begin
      unique case (key_mode)
         KM_192:  nr_sel = CNT_W'(NR_192);
         KM_256:  nr_sel = CNT_W'(NR_256);
         default: nr_sel = CNT_W'(NR_128);
      endcase
   end

   // Next-state logic
   always_comb begin
      state_d = state_q;
      round_d = round_q;
      nr_d    = nr_q;
      unique case (state_q)
         ST_IDLE: begin
            round_d = '0;
            if (start) begin
               nr_d    = nr_sel;
               state_d = ST_RUN;
            end
         end
         ST_RUN: begin
            if (abort) begin
               round_d = '0;
               state_d = ST_IDLE;
            end else if (cnt_en) begin
               if (round_q < nr_q) begin
                  round_d = round_q + {{(CNT_W-1){1'b0}}, 1'b1};
               end else begin
                  // round holds nr through DONE so it is visible with done
                  state_d = ST_DONE;
               end
            end
         end
         ST_DONE: begin
            round_d = '0;
            if (start) begin
               // back-to-back: skip IDLE and re-latch the round count
               nr_d    = nr_sel;
               state_d = ST_RUN;
            end else begin
               state_d = ST_IDLE;
            end
         end
         default: begin
            round_d = '0;
            state_d = ST_IDLE;
         end
      endcase
   end

   always_ff @(posedge clk) begin
      if (clr) begin
         state_q <= ST_IDLE;
         round_q <= '0;
         nr_q    <= CNT_W'(NR_128);
      end else begin
         state_q <= state_d;
         round_q <= round_d;
         nr_q    <= nr_d;
      end
   end

   assign busy  = (state_q == ST_RUN);
   assign done  = (state_q == ST_DONE);
   assign round = round_q;
   assign nr    = nr_q;

   aes_round_flags #(
      .CNT_W (CNT_W)
   ) u_flags (
      .state     (state_q),
      .round     (round_q),
      .nr        (nr_q),
      .first_rnd (first_rnd),
      .mix_en    (mix_en),
      .pre_last  (pre_last),
      .last_rnd  (last_rnd)
   );

endmodule : aes_round_sequencer
